lsu_mem_if: RTL and testbench

- Load/store unit between the RISC-V core's data-side outputs (aluout, writedata, MemWrite, ls) and a variable-latency data-memory bus.
- Converts byte/half/word accesses into word-aligned bus transactions with byte enables.
- Sign- or zero-extends load data and returns it as the core's readdata.
- Stalls the core until the access completes.

---
 rtl/lsu_mem_if.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned bus transactions.
// Optional response watchdog is compiled in with `define LSU_TIMEOUT_EN.
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        MemWrite,
  input  logic [3:0]  ls,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        misaligned;
  logic [31:0] lane;
  logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wd_cnt;
  logic          timeout;
  assign timeout = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign bus_err = 1'b0;
`endif

  // Reset forces stall low immediately, even while the core still presents a request.
  assign stall = !rst & (((state == IDLE) & ls[3]) | (state == REQ) | (state == WAIT_RSP));

  always_comb begin
    be_next    = 4'b0000;
    wdata_next = writedata;
    misaligned = 1'b0;
    case (ls[1:0])
      2'b00: begin
        be_next    = 4'b0001 << aluout[1:0];
        wdata_next = {4{writedata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << aluout[1:0];
        wdata_next = {2{writedata[15:0]}};
        misaligned = aluout[0];
      end
      2'b10: begin
        be_next    = 4'b1111;
        misaligned = (aluout[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Lane select uses the offset latched at request time, not the live core address.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      readdata  <= '0;
      misalign  <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err  <= 1'b0;
      wd_cnt   <= '0;
`endif
      case (state)
        IDLE: begin
          if (ls[3]) begin
            if (misaligned) begin
              misalign <= 1'b1;
              readdata <= '0;
              state    <= DONE;
            end else begin
              mem_valid <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {aluout[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              off_q     <= aluout[1:0];
              size_q    <= ls[1:0];
              uns_q     <= ls[2];
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_we) begin
              state <= DONE;
            end else if (mem_rvalid) begin
              readdata <= load_ext;
              state    <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            mem_valid <= 1'b0;
            bus_err   <= 1'b1;
            readdata  <= '0;
            state     <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        WAIT_RSP: begin
          if (mem_rvalid) begin
            readdata <= load_ext;
            state    <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            bus_err  <= 1'b1;
            readdata <= '0;
            state    <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomized self-checking bench for lsu_mem_if; the bench plays the core and the memory bus.
`timescale 1ns/1ps
module tb_lsu_mem_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluout, writedata, readdata, mem_addr, mem_wdata, mem_rdata;
  logic        MemWrite, stall, misalign, bus_err, mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [3:0]  ls, mem_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd   = '0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .aluout(aluout), .writedata(writedata), .MemWrite(MemWrite),
    .ls(ls), .readdata(readdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Single comparison point: every check is counted here and mismatches reported.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference rules for an access, written straight from the lane/extension arithmetic.
  function automatic bit ref_misalign(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] b;
    if (size == 2'd0)      b = 4'b0001;
    else if (size == 2'd1) b = 4'b0011;
    else                   return 4'b1111;
    return b << off;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * off);
    if (size == 2'd0) begin
      sh = sh & 32'hFF;
      if (!uns && sh[7]) sh = sh | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      sh = sh & 32'hFFFF;
      if (!uns && sh[15]) sh = sh | 32'hFFFF0000;
    end
    return sh;
  endfunction

  // Present one access, act as the bus (ready after rdly REQ cycles, response vdly cycles
  // after acceptance), and check bus fields, stall length and the DONE-cycle results.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                               input logic [3:0] lsv, input int rdly, input int vdly,
                               input logic [31:0] rdata, input bit expect_tmo);
    logic [1:0] size, off;
    bit mis, accepted, saw_valid;
    int stalls, req_n, wait_n, exp_stalls;
    size = lsv[1:0];
    off  = addr[1:0];
    mis  = ref_misalign(size, off);
    accepted = 0; saw_valid = 0; stalls = 0; req_n = 0; wait_n = 0;

    @(negedge clk);
    aluout = addr; writedata = wd; MemWrite = we; ls = lsv;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = rdata;

    for (int c = 0; c < 200; c++) begin
      #1;
      if (!stall) break;
      stalls++;
      if (mem_valid) begin
        saw_valid = 1;
        checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("mem_be", {28'b0, mem_be}, {28'b0, ref_be(size, off)});
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) checkOutput("mem_wdata", mem_wdata, ref_wdata(size, wd));
        if (req_n == rdly) begin
          mem_ready = 1;
          accepted  = 1;
          if (!we && vdly == 0) mem_rvalid = 1;
        end
        req_n++;
      end else if (accepted && !we) begin
        wait_n++;
        if (wait_n == vdly) mem_rvalid = 1;
      end
      @(negedge clk);
      mem_ready = 0; mem_rvalid = 0;
    end

    // Now in DONE (or the cycle budget ran out, which the stall check exposes).
    checkOutput("stall_done", {31'b0, stall}, 32'd0);
    if (expect_tmo)               exp_stalls = 2 + TMO;
    else if (mis)                 exp_stalls = 1;
    else if (we || vdly == 0)     exp_stalls = 2 + rdly;
    else                          exp_stalls = 2 + rdly + vdly;
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    checkOutput("misalign", {31'b0, misalign}, {31'b0, mis});
    checkOutput("bus_err", {31'b0, bus_err}, {31'b0, expect_tmo});
    checkOutput("bus_used", {31'b0, saw_valid}, {31'b0, !mis});
    checkOutput("mem_valid_done", {31'b0, mem_valid}, 32'd0);
    if (mis || expect_tmo) exp_rd = '0;
    else if (!we)          exp_rd = ref_load(size, lsv[2], off, rdata);
    checkOutput("readdata", readdata, exp_rd);

    ls = 4'b0000;
    @(negedge clk);
    #1;
    checkOutput("misalign_pulse", {31'b0, misalign}, 32'd0);
    checkOutput("bus_err_pulse", {31'b0, bus_err}, 32'd0);
    checkOutput("idle_stall", {31'b0, stall}, 32'd0);
  endtask

  // Hold a load in REQ with no ready, then reset mid-request and feed a stray response.
  task automatic resetMidRequest();
    @(negedge clk);
    aluout = 32'h0000_0400; ls = 4'b1010; MemWrite = 0; mem_ready = 0; mem_rvalid = 0;
    @(negedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      checkOutput("bp_valid", {31'b0, mem_valid}, 32'd1);
      checkOutput("bp_addr", mem_addr, 32'h0000_0400);
      checkOutput("bp_be", {28'b0, mem_be}, 32'hF);
      checkOutput("bp_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      #1;
    end
    rst = 1;
    #1;
    exp_rd = '0;
    checkOutput("rst_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_readdata", readdata, exp_rd);
    @(negedge clk);
    rst = 0; ls = 4'b0000; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checkOutput("stray_rsp_readdata", readdata, exp_rd);
    checkOutput("stray_rsp_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("stray_rsp_stall", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    logic [3:0] lsv;
    rst = 1; aluout = '0; writedata = '0; MemWrite = 0; ls = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("reset_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("reset_be", {28'b0, mem_be}, 32'd0);
    rst = 0;

    // Directed scenarios from the test plan.
    applyStimulus(32'h0000_0103, 32'h0000_00AB, 1'b1, 4'b1000, 0, 0, 32'h0, 1'b0);
    applyStimulus(32'h0000_0202, 32'h0, 1'b0, 4'b1001, 0, 3, 32'h8001_1234, 1'b0);
    applyStimulus(32'h0000_0201, 32'h0, 1'b0, 4'b1100, 0, 0, 32'h0000_F100, 1'b0);
    applyStimulus(32'h0000_0302, 32'h0, 1'b0, 4'b1010, 0, 0, 32'h1234_5678, 1'b0);
    resetMidRequest();

    // Random accesses with short bus delays, interleaved with idle cycles.
    for (int i = 0; i < 60; i++) begin
      lsv = {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), lsv,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        ls = {1'b0, 3'($urandom_range(0, 7))};
        #1;
        checkOutput("idle_no_stall", {31'b0, stall}, 32'd0);
        checkOutput("idle_no_valid", {31'b0, mem_valid}, 32'd0);
      end
    end

`ifdef LSU_TIMEOUT_EN
    applyStimulus(32'h0000_0500, 32'h0, 1'b0, 4'b1010, 0, 100000, 32'hCAFE_F00D, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
